// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the requester state encoding,
// used by the master, the peripheral slaves and their benches.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RDWAIT,
    RESP
  } apb_mst_st_e;

endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB requester. Takes one command at a time over a
// valid/ready port, runs SETUP then ACCESS on the bus (with wait states and
// a timeout), optionally waits one cycle for registered read data, and
// returns a one-cycle response pulse.
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int RD_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [APB_ADDR_W-1:0] cmd_addr,
  input  logic [APB_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [APB_ADDR_W-1:0] paddr,
  output logic [APB_DATA_W-1:0] pwdata,
  input  logic                  pready,
  input  logic [APB_DATA_W-1:0] prdata
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  apb_mst_st_e             state;
  apb_mst_st_e             state_nxt;
  logic                    run_q;
  logic                    write_q;
  logic [APB_ADDR_W-1:0]   addr_q;
  logic [APB_DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]        wait_cnt;

  logic                    take;
  logic                    cnt_inc;
  logic                    rsp_load;
  logic                    err_set;
  logic [APB_DATA_W-1:0]   rsp_data_nxt;

  // Bus and command-port outputs are pure decodes of the state and the
  // registered command; pwdata was already zeroed for reads when latched.
  assign cmd_ready = run_q && (state == IDLE);
  assign psel      = (state == SETUP) || (state == ACCESS);
  assign penable   = (state == ACCESS);
  assign rsp_valid = (state == RESP);
  assign pwrite    = write_q;
  assign paddr     = addr_q;
  assign pwdata    = wdata_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the strobes that steer the datapath registers.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    cnt_inc   = 1'b0;
    rsp_load  = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          take      = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          if (write_q || (RD_LAT == 0)) begin
            rsp_load  = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = RDWAIT;
          end
        end else if (wait_cnt == CNT_MAX) begin
          rsp_load  = 1'b1;
          err_set   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RDWAIT: begin
        rsp_load  = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    rsp_data_nxt = (err_set || write_q) ? '0 : prdata;
  end

  // Command capture, wait counter and response registers; run_q holds
  // cmd_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (take) begin
        write_q  <= cmd_write;
        addr_q   <= cmd_addr;
        wdata_q  <= cmd_write ? cmd_wdata : '0;
        wait_cnt <= '0;
      end else if (cnt_inc) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (rsp_load) begin
        rsp_rdata <= rsp_data_nxt;
        rsp_err   <= err_set;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: a registered-read slave with a
// programmable number of wait states, directed bring-up transfers, a
// back-to-back queue, a mid-transfer reset and randomized traffic, all
// compared against a transaction-level reference model.
module tb_apb_master;
  import apb_pkg::*;

  localparam int TO = 4;
  localparam int RL = 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [APB_ADDR_W-1:0] cmd_addr;
  logic [APB_DATA_W-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [APB_DATA_W-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_ADDR_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic                  pready;
  logic [APB_DATA_W-1:0] prdata = '0;

  logic [31:0] slave_mem [256];
  logic [31:0] model_mem [256];
  int acc_cnt = 0;
  int cur_waits = 0;
  int hs_count = 0;
  int rsp_count = 0;
  int total = 0;
  int bad = 0;

  apb_master #(.TIMEOUT(TO), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pready(pready), .prdata(prdata)
  );

  always #5 clk = ~clk;

  // Slave holds pready low for the first cur_waits ACCESS cycles.
  assign pready = !(psel && penable) || (acc_cnt >= cur_waits);

  // Registered-read slave plus handshake/response counters.
  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else if (!penable) acc_cnt <= 0;
    if (psel && penable && pready) begin
      if (pwrite) slave_mem[paddr] <= pwdata;
      else prdata <= slave_mem[paddr];
    end
    if (cmd_valid && cmd_ready) hs_count <= hs_count + 1;
    if (rsp_valid) rsp_count <= rsp_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One full transfer; the expected latency and response come from the
  // transfer rules (cycles counted from the handshake edge).
  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                               input int waits, input logic keep_valid);
    int exp_lat;
    logic [31:0] exp_rdata;
    logic exp_err;
    logic seen;
    logic ready_busy;
    int n;
    exp_err = (waits > TO);
    if (exp_err) exp_lat = TO + 3;
    else exp_lat = 3 + waits + ((!wr && RL == 1) ? 1 : 0);
    exp_rdata = (wr || exp_err) ? 32'h0 : model_mem[addr];
    cur_waits = waits;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_ready_wait", cmd_ready, 1);
    @(posedge clk);
    #1;
    if (!keep_valid) cmd_valid = 1'b0;
    seen = 1'b0;
    ready_busy = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checkOutput("setup_psel", psel, 1);
        checkOutput("setup_penable", penable, 0);
        checkOutput("setup_paddr", paddr, addr);
        checkOutput("setup_pwrite", pwrite, wr);
        checkOutput("setup_pwdata", pwdata, wr ? data : 32'h0);
      end
      if (c == 2) begin
        checkOutput("access_psel", psel, 1);
        checkOutput("access_penable", penable, 1);
        checkOutput("access_paddr", paddr, addr);
        checkOutput("access_pwdata", pwdata, wr ? data : 32'h0);
      end
      if (rsp_valid) begin
        seen = 1'b1;
        checkOutput("rsp_cycle", c, exp_lat);
        checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
        checkOutput("rsp_err", rsp_err, exp_err);
        checkOutput("rsp_bus_idle", {psel, penable}, 0);
      end else if (cmd_ready) begin
        ready_busy = 1'b1;
      end
    end
    checkOutput("rsp_seen", seen, 1);
    checkOutput("ready_while_busy", ready_busy, 0);
    @(negedge clk);
    checkOutput("rsp_one_cycle", rsp_valid, 0);
    checkOutput("ready_after", cmd_ready, 1);
    checkOutput("rdata_held", rsp_rdata, exp_rdata);
    if (wr && !exp_err) model_mem[addr] = data;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hb;
    int rb;
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = '0;
      model_mem[i] = '0;
    end
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;

    #3;
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_bus", {psel, penable, pwrite}, 0);
    checkOutput("rst_paddr", paddr, 0);
    checkOutput("rst_pwdata", pwdata, 0);
    checkOutput("rst_rsp", {rsp_valid, rsp_err}, 0);
    checkOutput("rst_rdata", rsp_rdata, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", cmd_ready, 1);

    applyStimulus(1'b1, 8'h10, 32'h0000_00A5, 0, 1'b0);
    applyStimulus(1'b0, 8'h10, 32'h0, 0, 1'b0);
    applyStimulus(1'b1, 8'h22, 32'hDEAD_BEEF, 3, 1'b0);
    applyStimulus(1'b0, 8'h22, 32'h0, 3, 1'b0);
    applyStimulus(1'b0, 8'h10, 32'h0, TO, 1'b0);
    applyStimulus(1'b1, 8'h10, 32'h1234_5678, TO + 5, 1'b0);
    applyStimulus(1'b0, 8'h10, 32'h0, TO + 1, 1'b0);
    applyStimulus(1'b0, 8'h10, 32'h0, 0, 1'b0);

    hb = hs_count;
    rb = rsp_count;
    applyStimulus(1'b1, 8'h30, 32'hAAAA_0001, 1, 1'b1);
    applyStimulus(1'b1, 8'h31, 32'hAAAA_0002, 0, 1'b1);
    applyStimulus(1'b0, 8'h30, 32'h0, 2, 1'b0);
    checkOutput("queue_handshakes", hs_count - hb, 3);
    checkOutput("queue_responses", rsp_count - rb, 3);

    cur_waits = 100;
    cmd_write = 1'b0;
    cmd_addr  = 8'h31;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_rst_access", {psel, penable}, 2'b11);
    rb = rsp_count;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_bus", {psel, penable}, 0);
    checkOutput("async_rst_ready", cmd_ready, 0);
    checkOutput("async_rst_rsp", rsp_valid, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_no_response", rsp_count - rb, 0);
    checkOutput("ready_after_rst2", cmd_ready, 1);
    applyStimulus(1'b0, 8'h31, 32'h0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic wr;
      logic [7:0] a;
      logic [31:0] d;
      int w;
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 15));
      d  = $urandom;
      w  = $urandom_range(0, 6);
      applyStimulus(wr, a, d, w, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
